// File: rtl/yapay_zeka_tampon_obegi_pkg.sv
// Shared defaults and helpers for the AI X-extension operand buffer.
// Optional error counter: define YAPAY_ZEKA_HATA_SAYACI_EN at build time.
package yapay_zeka_tampon_obegi_pkg;

   localparam int unsigned VARSAYILAN_VERI_BIT = 32;
   localparam int unsigned VARSAYILAN_DERINLIK = 16;
   localparam int unsigned HATA_SAYAC_BIT      = 16;

   // Words requested this cycle; an orphan second enable requests nothing.
   function automatic logic [1:0] yazma_sayisi(input logic yaz1_en, input logic yaz2_en);
      logic [1:0] nw;
      nw = 2'd0;
      if (yaz1_en && yaz2_en) begin
         nw = 2'd2;
      end else if (yaz1_en) begin
         nw = 2'd1;
      end
      return nw;
   endfunction

endpackage

// File: rtl/yapay_zeka_bellek_dizisi.sv
// Two-write-port, one-asynchronous-read-port storage array for the operand buffer.
// Contents are intentionally not reset.
module yapay_zeka_bellek_dizisi
   import yapay_zeka_tampon_obegi_pkg::*;
#(
   parameter int unsigned VERI_BIT = VARSAYILAN_VERI_BIT,
   parameter int unsigned DERINLIK = VARSAYILAN_DERINLIK,
   localparam int unsigned ADR_BIT = $clog2(DERINLIK)
) (
   input  logic                clk_i,
   input  logic                yaz1_en_i,
   input  logic [ADR_BIT-1:0]  yaz1_adr_i,
   input  logic [VERI_BIT-1:0] yaz1_deger_i,
   input  logic                yaz2_en_i,
   input  logic [ADR_BIT-1:0]  yaz2_adr_i,
   input  logic [VERI_BIT-1:0] yaz2_deger_i,
   input  logic [ADR_BIT-1:0]  oku_adr_i,
   output logic [VERI_BIT-1:0] oku_deger_o
);

   logic [VERI_BIT-1:0] mem [DERINLIK];

   // The two write addresses are always consecutive, so they never collide.
   always_ff @(posedge clk_i) begin
      if (yaz1_en_i) begin
         mem[yaz1_adr_i] <= yaz1_deger_i;
      end
      if (yaz2_en_i) begin
         mem[yaz2_adr_i] <= yaz2_deger_i;
      end
   end

   assign oku_deger_o = mem[oku_adr_i];

endmodule

// File: rtl/yapay_zeka_tampon_obegi.sv
// Circular operand buffer: up to two in-order writes and one read per cycle, with overflow/underflow flagging.
// Optional saturating error counter enabled by YAPAY_ZEKA_HATA_SAYACI_EN.
module yapay_zeka_tampon_obegi
   import yapay_zeka_tampon_obegi_pkg::*;
#(
   parameter int unsigned VERI_BIT = VARSAYILAN_VERI_BIT,
   parameter int unsigned DERINLIK = VARSAYILAN_DERINLIK,
   localparam int unsigned ADR_BIT = $clog2(DERINLIK)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                yaz1_en_i,
   input  logic [VERI_BIT-1:0] yaz1_deger_i,
   input  logic                yaz2_en_i,
   input  logic [VERI_BIT-1:0] yaz2_deger_i,
   output logic                yaz_hazir_o,
   input  logic                oku_en_i,
   output logic [VERI_BIT-1:0] oku_deger_o,
   output logic                oku_gecerli_o,
   output logic [ADR_BIT:0]    doluluk_o,
   input  logic                temizle_i,
`ifdef YAPAY_ZEKA_HATA_SAYACI_EN
   output logic [HATA_SAYAC_BIT-1:0] hata_sayisi_o,
`endif
   output logic                hata_o
);

   localparam int unsigned SAY_BIT = ADR_BIT + 1;

   logic [ADR_BIT-1:0]  wp, rp;
   logic [SAY_BIT-1:0]  sayac;
   logic                hata;

   logic [1:0]          nw;
   logic [SAY_BIT-1:0]  bos_yer;
   logic                yetim_yaz2;
   logic                yaz_kabul, yaz_red;
   logic                oku_kabul, oku_red;
   logic                hata_olay;
   logic                bellek_yaz1, bellek_yaz2;
   logic [VERI_BIT-1:0] bas_deger;

   // Acceptance is judged on the pre-edge count; no credit for a same-cycle pop.
   always_comb begin
      nw         = yazma_sayisi(yaz1_en_i, yaz2_en_i);
      bos_yer    = SAY_BIT'(DERINLIK) - sayac;
      yetim_yaz2 = yaz2_en_i && !yaz1_en_i;
      yaz_kabul  = (nw != 2'd0) && (SAY_BIT'(nw) <= bos_yer);
      yaz_red    = (nw != 2'd0) && !yaz_kabul;
      oku_kabul  = oku_en_i && (sayac != '0);
      oku_red    = oku_en_i && (sayac == '0);
      hata_olay  = yetim_yaz2 || yaz_red || oku_red;
   end

   // Flush and reset both abort any storage write in the same cycle.
   assign bellek_yaz1 = yaz_kabul && !temizle_i && !rst_i;
   assign bellek_yaz2 = bellek_yaz1 && (nw == 2'd2);

   yapay_zeka_bellek_dizisi #(
      .VERI_BIT (VERI_BIT),
      .DERINLIK (DERINLIK)
   ) u_bellek (
      .clk_i        (clk_i),
      .yaz1_en_i    (bellek_yaz1),
      .yaz1_adr_i   (wp),
      .yaz1_deger_i (yaz1_deger_i),
      .yaz2_en_i    (bellek_yaz2),
      .yaz2_adr_i   (wp + ADR_BIT'(1)),
      .yaz2_deger_i (yaz2_deger_i),
      .oku_adr_i    (rp),
      .oku_deger_o  (bas_deger)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp    <= '0;
         rp    <= '0;
         sayac <= '0;
         hata  <= 1'b0;
      end else if (temizle_i) begin
         wp    <= '0;
         rp    <= '0;
         sayac <= '0;
         hata  <= 1'b0;
      end else begin
         if (yaz_kabul) begin
            wp <= wp + ADR_BIT'(nw);
         end
         if (oku_kabul) begin
            rp <= rp + ADR_BIT'(1);
         end
         sayac <= sayac + (yaz_kabul ? SAY_BIT'(nw) : '0) - SAY_BIT'(oku_kabul);
         if (hata_olay) begin
            hata <= 1'b1;
         end
      end
   end

`ifdef YAPAY_ZEKA_HATA_SAYACI_EN
   logic [HATA_SAYAC_BIT-1:0] hata_sayisi;

   // One count per offending cycle, saturating.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hata_sayisi <= '0;
      end else if (temizle_i) begin
         hata_sayisi <= '0;
      end else if (hata_olay && (hata_sayisi != {HATA_SAYAC_BIT{1'b1}})) begin
         hata_sayisi <= hata_sayisi + HATA_SAYAC_BIT'(1);
      end
   end

   assign hata_sayisi_o = hata_sayisi;
`endif

   assign oku_gecerli_o = (sayac != '0);
   assign oku_deger_o   = oku_gecerli_o ? bas_deger : '0;
   assign yaz_hazir_o   = (bos_yer >= SAY_BIT'(2));
   assign doluluk_o     = sayac;
   assign hata_o        = hata;

endmodule

// File: tb/tb_yapay_zeka_tampon_obegi.sv
// Directed self-checking bench for the operand buffer (DERINLIK = 16, VERI_BIT = 32).
module tb_yapay_zeka_tampon_obegi;

   logic        clk = 1'b0;
   logic        rst;
   logic        yaz1_en, yaz2_en, oku_en, temizle;
   logic [31:0] yaz1_deger, yaz2_deger;
   logic        yaz_hazir, oku_gecerli, hata;
   logic [31:0] oku_deger;
   logic [4:0]  doluluk;
`ifdef YAPAY_ZEKA_HATA_SAYACI_EN
   logic [15:0] hata_sayisi;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   yapay_zeka_tampon_obegi #(.VERI_BIT(32), .DERINLIK(16)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .yaz1_en_i     (yaz1_en),
      .yaz1_deger_i  (yaz1_deger),
      .yaz2_en_i     (yaz2_en),
      .yaz2_deger_i  (yaz2_deger),
      .yaz_hazir_o   (yaz_hazir),
      .oku_en_i      (oku_en),
      .oku_deger_o   (oku_deger),
      .oku_gecerli_o (oku_gecerli),
      .doluluk_o     (doluluk),
      .temizle_i     (temizle),
`ifdef YAPAY_ZEKA_HATA_SAYACI_EN
      .hata_sayisi_o (hata_sayisi),
`endif
      .hata_o        (hata)
   );

   // Drive one cycle of inputs, then leave the bench 1 ns past the rising edge.
   task automatic adim(input logic y1, input logic [31:0] d1, input logic y2,
                       input logic [31:0] d2, input logic o, input logic t);
      yaz1_en = y1; yaz1_deger = d1; yaz2_en = y2; yaz2_deger = d2;
      oku_en = o; temizle = t;
      @(posedge clk);
      #1;
      yaz1_en = 1'b0; yaz2_en = 1'b0; oku_en = 1'b0; temizle = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      yaz1_en = 1'b0; yaz2_en = 1'b0; oku_en = 1'b0; temizle = 1'b0;
      yaz1_deger = '0; yaz2_deger = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (doluluk !== 5'd0 || oku_gecerli !== 1'b0 || yaz_hazir !== 1'b1 ||
          oku_deger !== 32'h0 || hata !== 1'b0) begin
         errors++;
         $display("FAIL reset: cnt=%0d gec=%b hazir=%b deger=%h hata=%b, want 0 0 1 0 0",
                  doluluk, oku_gecerli, yaz_hazir, oku_deger, hata);
      end
      rst = 1'b0;
   endtask

   task automatic test_fifo_order();
      for (int i = 0; i < 8; i++) begin
         adim(1'b1, 32'h100 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
      end
      checks++;
      if (doluluk !== 5'd8) begin
         errors++;
         $display("FAIL fifo_fill_cnt: got %0d want 8", doluluk);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (oku_deger !== 32'h100 + 32'(i) || doluluk !== 5'(8 - i)) begin
            errors++;
            $display("FAIL fifo_read[%0d]: got %h cnt %0d want %h cnt %0d",
                     i, oku_deger, doluluk, 32'h100 + 32'(i), 8 - i);
         end
         adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      end
      checks++;
      if (doluluk !== 5'd0 || oku_gecerli !== 1'b0 || hata !== 1'b0) begin
         errors++;
         $display("FAIL fifo_drained: cnt=%0d gec=%b hata=%b want 0 0 0", doluluk, oku_gecerli, hata);
      end
   endtask

   // Pointers are at 8; seven write/read pairs bring both to 15.
   task automatic test_wrap();
      for (int i = 0; i < 7; i++) adim(1'b1, 32'hDEAD0000 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      adim(1'b1, 32'hAAAA, 1'b1, 32'hBBBB, 1'b0, 1'b0);
      checks++;
      if (doluluk !== 5'd2 || oku_deger !== 32'hAAAA) begin
         errors++;
         $display("FAIL wrap_first: got %h cnt %0d want aaaa cnt 2", oku_deger, doluluk);
      end
      adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (oku_deger !== 32'hBBBB || doluluk !== 5'd1) begin
         errors++;
         $display("FAIL wrap_second: got %h cnt %0d want bbbb cnt 1", oku_deger, doluluk);
      end
      adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (doluluk !== 5'd0 || hata !== 1'b0) begin
         errors++;
         $display("FAIL wrap_drained: cnt %0d hata %b want 0 0", doluluk, hata);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 15; i++) adim(1'b1, 32'h200 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (doluluk !== 5'd15 || yaz_hazir !== 1'b0 || hata !== 1'b0) begin
         errors++;
         $display("FAIL full_15: cnt %0d hazir %b hata %b want 15 0 0", doluluk, yaz_hazir, hata);
      end
      adim(1'b1, 32'h777, 1'b1, 32'h888, 1'b0, 1'b0);
      checks++;
      if (doluluk !== 5'd15 || hata !== 1'b1) begin
         errors++;
         $display("FAIL full_dual_reject: cnt %0d hata %b want 15 1", doluluk, hata);
      end
      adim(1'b1, 32'h2FF, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (doluluk !== 5'd16 || hata !== 1'b1 || yaz_hazir !== 1'b0 || oku_deger !== 32'h200) begin
         errors++;
         $display("FAIL full_single_ok: cnt %0d hata %b hazir %b head %h want 16 1 0 200",
                  doluluk, hata, yaz_hazir, oku_deger);
      end
   endtask

   task automatic test_same_cycle_rw();
      adim(1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (doluluk !== 5'd15 || oku_deger !== 32'h201) begin
         errors++;
         $display("FAIL full_rw: cnt %0d head %h want 15 201", doluluk, oku_deger);
      end
      adim(1'b1, 32'h555, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (doluluk !== 5'd0 || hata !== 1'b0 || oku_gecerli !== 1'b0 || oku_deger !== 32'h0) begin
         errors++;
         $display("FAIL flush_discard: cnt %0d hata %b gec %b deger %h want 0 0 0 0",
                  doluluk, hata, oku_gecerli, oku_deger);
      end
      adim(1'b1, 32'h333, 1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (doluluk !== 5'd1 || oku_deger !== 32'h333 || hata !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw: cnt %0d head %h hata %b want 1 333 1", doluluk, oku_deger, hata);
      end
      adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_errors();
      adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      adim(1'b0, 32'h0, 1'b1, 32'h1234, 1'b0, 1'b0);
      checks++;
      if (hata !== 1'b1 || doluluk !== 5'd0 || oku_gecerli !== 1'b0) begin
         errors++;
         $display("FAIL err_flag: hata %b cnt %0d gec %b want 1 0 0", hata, doluluk, oku_gecerli);
      end
`ifdef YAPAY_ZEKA_HATA_SAYACI_EN
      checks++;
      if (hata_sayisi !== 16'd2) begin
         errors++;
         $display("FAIL err_count: got %0d want 2", hata_sayisi);
      end
      adim(1'b0, 32'h0, 1'b1, 32'h1, 1'b1, 1'b0);
      checks++;
      if (hata_sayisi !== 16'd3) begin
         errors++;
         $display("FAIL err_count_double: got %0d want 3", hata_sayisi);
      end
`endif
      adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (hata !== 1'b0 || doluluk !== 5'd0) begin
         errors++;
         $display("FAIL err_clear: hata %b cnt %0d want 0 0", hata, doluluk);
      end
`ifdef YAPAY_ZEKA_HATA_SAYACI_EN
      checks++;
      if (hata_sayisi !== 16'd0) begin
         errors++;
         $display("FAIL err_count_clear: got %0d want 0", hata_sayisi);
      end
`endif
   endtask

   task automatic test_async_reset();
      adim(1'b1, 32'hC0, 1'b1, 32'hC1, 1'b0, 1'b0);
      adim(1'b1, 32'hC2, 1'b0, 32'h0, 1'b1, 1'b0);
      adim(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      checks++;
      if (doluluk !== 5'd2 || oku_deger !== 32'hC1 || hata !== 1'b1) begin
         errors++;
         $display("FAIL burst_pre_reset: cnt %0d head %h hata %b want 2 c1 1", doluluk, oku_deger, hata);
      end
      yaz1_en = 1'b1; yaz1_deger = 32'hEE; oku_en = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (doluluk !== 5'd0 || oku_deger !== 32'h0 || yaz_hazir !== 1'b1 ||
          oku_gecerli !== 1'b0 || hata !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: cnt %0d deger %h hazir %b gec %b hata %b want 0 0 1 0 0",
                  doluluk, oku_deger, yaz_hazir, oku_gecerli, hata);
      end
      @(posedge clk);
      #1;
      yaz1_en = 1'b0; oku_en = 1'b0;
      rst = 1'b0;
      adim(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (doluluk !== 5'd0 || oku_gecerli !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: cnt %0d gec %b want 0 0", doluluk, oku_gecerli);
      end
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_wrap();
      test_full();
      test_same_cycle_rw();
      test_errors();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
